// File: rtl/i2c_eeprom_responder.sv
// rtl/i2c_eeprom_responder.sv - I2C target emulating a 16-byte serial EEPROM
module i2c_eeprom_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter bit         LSB_FIRST = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  input  logic [3:0] DBG_ADDR,
  output logic [7:0] DBG_DATA,
  output logic       WR_STROBE,
  output logic [3:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       BUSY
);

  typedef enum logic [2:0] {S_IDLE, S_DEVADR, S_WORDADR, S_WDATA, S_RDATA} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic [3:0] ptr_q, ptr_d;
  logic [7:0] sr_q, sr_d;
  logic       we_d;
  logic [7:0] mem_q [16];
  logic       wr_strobe_q;
  logic [3:0] wr_addr_q;
  logic [7:0] wr_data_q;

  logic scl_s1_q, scl_s2_q, scl_p_q, sda_s1_q, sda_s2_q, sda_p_q;
  logic scl_rise_q, scl_fall_q, start_q, stop_q;

  logic       rx_bit;
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;

  function automatic logic [2:0] bit_idx(input logic [2:0] n);
    return LSB_FIRST ? n : 3'd7 - n;
  endfunction

  // Idle-high reset of the synchronisers keeps a quiet bus from looking like an edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_p_q    <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_s1_q   <= I2C_SCLK;
      scl_s2_q   <= scl_s1_q;
      scl_p_q    <= scl_s2_q;
      sda_s1_q   <= I2C_SDAT;
      sda_s2_q   <= sda_s1_q;
      sda_p_q    <= sda_s2_q;
      scl_rise_q <= scl_s2_q & ~scl_p_q;
      scl_fall_q <= ~scl_s2_q & scl_p_q;
      start_q    <= scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
      stop_q     <= scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
    end
  end

  // sda_p_q is the SDA value captured alongside the registered SCL edge.
  assign rx_bit  = sda_p_q;
  assign rx_byte = (state_q == S_DEVADR || !LSB_FIRST) ? {sr_q[6:0], rx_bit}
                                                       : {rx_bit, sr_q[7:1]};
  assign rd_byte = mem_q[ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    sr_d    = sr_q;
    we_d    = 1'b0;
    if (stop_q) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      ack_d   = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_q) begin
      state_d = S_DEVADR;
      cnt_d   = 4'd0;
      ack_d   = 1'b0;
      oe_d    = 1'b0;
    end else if (state_q != S_IDLE) begin
      if (scl_rise_q) begin
        if (!ack_q && cnt_q < 4'd8) begin
          cnt_d = cnt_q + 4'd1;
          sr_d  = rx_byte;
          if (cnt_q == 4'd7 && state_q == S_WORDADR) ptr_d = rx_byte[3:0];
          if (cnt_q == 4'd7 && state_q == S_WDATA) begin
            we_d  = 1'b1;
            ptr_d = ptr_q + 4'd1;
          end
        end else if (ack_q && state_q == S_RDATA && rx_bit) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          ack_d   = 1'b0;
          busy_d  = 1'b0;
        end
      end else if (scl_fall_q) begin
        if (ack_q) begin
          // End of the ACK slot: state changes here so the slot itself is never misread.
          ack_d = 1'b0;
          cnt_d = 4'd0;
          oe_d  = 1'b0;
          case (state_q)
            S_DEVADR:  state_d = sr_q[0] ? S_RDATA : S_WORDADR;
            S_WORDADR: state_d = S_WDATA;
            default:   state_d = state_q;
          endcase
          if (state_q == S_RDATA || (state_q == S_DEVADR && sr_q[0]))
            oe_d = ~rd_byte[bit_idx(3'd0)];
        end else if (cnt_q == 4'd8) begin
          ack_d = 1'b1;
          case (state_q)
            S_DEVADR: begin
              if (sr_q[7:1] == DEV_ADDR) begin
                oe_d   = 1'b1;
                busy_d = 1'b1;
              end else begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                ack_d   = 1'b0;
                busy_d  = 1'b0;
              end
            end
            S_RDATA: begin
              oe_d  = 1'b0;
              ptr_d = ptr_q + 4'd1;
            end
            default: oe_d = 1'b1;
          endcase
        end else if (state_q == S_RDATA) begin
          oe_d = ~rd_byte[bit_idx(cnt_q[2:0])];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      ack_q       <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= 4'd0;
      sr_q        <= 8'h00;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'd0;
      wr_data_q   <= 8'h00;
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      sr_q        <= sr_d;
      wr_strobe_q <= we_d;
      if (we_d) begin
        wr_addr_q     <= ptr_q;
        wr_data_q     <= rx_byte;
        mem_q[ptr_q]  <= rx_byte;
      end
    end
  end

  assign I2C_SDAT  = oe_q ? 1'b0 : 1'bz;
  assign DBG_DATA  = mem_q[DBG_ADDR];
  assign WR_STROBE = wr_strobe_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// tb/tb_i2c_eeprom_responder.sv - scoreboard bench for i2c_eeprom_responder
module tb_i2c_eeprom_responder;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_lo = 1'b0;
  wire        sda;
  logic [3:0] dbg_addr = 4'd0;
  logic [7:0] dbg_data;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic [11:0] exp_wr[$];
  logic [7:0]  exp_b[$];
  logic [7:0]  obs_b[$];
  string       exp_n[$];

  assign sda = sda_lo ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_eeprom_responder dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .I2C_SCLK  (scl),
    .I2C_SDAT  (sda),
    .DBG_ADDR  (dbg_addr),
    .DBG_DATA  (dbg_data),
    .WR_STROBE (wr_strobe),
    .WR_ADDR   (wr_addr),
    .WR_DATA   (wr_data),
    .BUSY      (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Monitor: pairs every DUT output event with the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_strobe) begin
        if (exp_wr.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_wr_strobe: got addr %0h data %0h, expected none", wr_addr, wr_data);
        end else begin
          check("wr_strobe", 32'({wr_addr, wr_data}), 32'(exp_wr.pop_front()));
        end
      end
      if (obs_b.size() > 0 && exp_b.size() > 0)
        check(exp_n.pop_front(), 32'(obs_b.pop_front()), 32'(exp_b.pop_front()));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic expect_b(input string nm, input logic [7:0] v);
    exp_n.push_back(nm);
    exp_b.push_back(v);
  endtask

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sda_lo = ~b; wq();
    scl = 1'b1;  wq();
    s = sda;     wq();
    scl = 1'b0;  wq();
  endtask

  task automatic i2c_start();
    sda_lo = 1'b0; wq();
    scl = 1'b1;    wq();
    sda_lo = 1'b1; wq();
    scl = 1'b0;    wq();
  endtask

  task automatic i2c_stop();
    sda_lo = 1'b1; wq();
    scl = 1'b1;    wq();
    sda_lo = 1'b0; wq();
  endtask

  task automatic wr_byte(input logic [7:0] b, input bit msb, input bit acked, input string nm);
    logic s;
    expect_b(nm, acked ? 8'h00 : 8'h01);
    for (int i = 0; i < 8; i++) bit_xfer(msb ? b[7-i] : b[i], s);
    bit_xfer(1'b1, s);
    obs_b.push_back({7'd0, s});
  endtask

  task automatic rd_byte(input bit ack, input logic [7:0] want, input string nm);
    logic       s;
    logic [7:0] v;
    expect_b(nm, want);
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, s);
      v[i] = s;
    end
    bit_xfer(ack ? 1'b0 : 1'b1, s);
    obs_b.push_back(v);
  endtask

  task automatic dbg_check(input logic [3:0] a, input logic [7:0] want, input string nm);
    dbg_addr = a;
    #1;
    check(nm, 32'(dbg_data), 32'(want));
  endtask

  initial begin
    logic       s;
    logic [7:0] d;
    logic [7:0] seqd [5];
    seqd = '{8'hE1, 8'hF2, 8'h0A, 8'h1B, 8'h2C};

    repeat (5) @(posedge clk);
    #1;
    check("reset_sda_z", 32'(sda), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_wr_strobe", 32'(wr_strobe), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    check("reset_wr_data", 32'(wr_data), 32'd0);
    dbg_check(4'd0, 8'h00, "reset_mem0");
    rst_n = 1'b1;
    wq();

    // byte write 0x3C to address 5
    i2c_start();
    wr_byte(8'hA0, 1'b1, 1'b1, "t1_ctl_ack");
    wr_byte(8'h05, 1'b0, 1'b1, "t1_word_ack");
    exp_wr.push_back({4'd5, 8'h3C});
    wr_byte(8'h3C, 1'b0, 1'b1, "t1_data_ack");
    check("t1_busy_high", 32'(busy), 32'd1);
    i2c_stop();
    check("t1_busy_after_stop", 32'(busy), 32'd0);
    dbg_check(4'd5, 8'h3C, "t1_dbg_mem5");

    // random read of address 5
    i2c_start();
    wr_byte(8'hA0, 1'b1, 1'b1, "t2_ctl_ack");
    wr_byte(8'h05, 1'b0, 1'b1, "t2_word_ack");
    i2c_start();
    wr_byte(8'hA1, 1'b1, 1'b1, "t2_rd_ctl_ack");
    check("t2_busy_reading", 32'(busy), 32'd1);
    rd_byte(1'b0, 8'h3C, "t2_rd_data");
    check("t2_busy_after_nack", 32'(busy), 32'd0);
    i2c_stop();

    // fill 14,15,0,1,2 with a wrapping sequential write
    i2c_start();
    wr_byte(8'hA0, 1'b1, 1'b1, "pre_ctl_ack");
    wr_byte(8'h0E, 1'b0, 1'b1, "pre_word_ack");
    for (int i = 0; i < 5; i++) begin
      exp_wr.push_back({4'(14 + i), seqd[i]});
      wr_byte(seqd[i], 1'b0, 1'b1, "pre_data_ack");
    end
    i2c_stop();

    // sequential read from 14 across the wrap, then current-address read shows ptr=2
    i2c_start();
    wr_byte(8'hA0, 1'b1, 1'b1, "t3_ctl_ack");
    wr_byte(8'h0E, 1'b0, 1'b1, "t3_word_ack");
    i2c_start();
    wr_byte(8'hA1, 1'b1, 1'b1, "t3_rd_ctl_ack");
    rd_byte(1'b1, 8'hE1, "t3_rd_mem14");
    rd_byte(1'b1, 8'hF2, "t3_rd_mem15");
    rd_byte(1'b1, 8'h0A, "t3_rd_mem0");
    rd_byte(1'b0, 8'h1B, "t3_rd_mem1");
    i2c_stop();
    i2c_start();
    wr_byte(8'hA1, 1'b1, 1'b1, "t3_cur_ctl_ack");
    rd_byte(1'b0, 8'h2C, "t3_cur_rd_ptr2");
    i2c_stop();

    // wrong device address
    i2c_start();
    wr_byte(8'hA2, 1'b1, 1'b0, "t4_no_ack");
    check("t4_busy_low", 32'(busy), 32'd0);
    i2c_stop();

    // STOP after a partial data byte, then reset in a read ACK slot
    i2c_start();
    wr_byte(8'hA0, 1'b1, 1'b1, "t5_ctl_ack");
    wr_byte(8'h03, 1'b0, 1'b1, "t5_word_ack");
    for (int i = 0; i < 5; i++) bit_xfer(1'(i & 1), s);
    i2c_stop();
    dbg_check(4'd3, 8'h00, "t5_partial_discarded");
    i2c_start();
    d = 8'hA1;
    for (int i = 0; i < 8; i++) bit_xfer(d[7-i], s);
    sda_lo = 1'b0; wq();
    scl = 1'b1;    wq();
    check("t5_ack_driven", 32'(sda), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t5_sda_released", 32'(sda), 32'd1);
    check("t5_busy_reset", 32'(busy), 32'd0);
    dbg_check(4'd5, 8'h00, "t5_mem5_cleared");
    dbg_check(4'd14, 8'h00, "t5_mem14_cleared");
    wq();
    rst_n = 1'b1;
    wq();

    // 17-byte write from address 0 wraps onto address 0
    i2c_start();
    wr_byte(8'hA0, 1'b1, 1'b1, "t6_ctl_ack");
    wr_byte(8'h00, 1'b0, 1'b1, "t6_word_ack");
    for (int i = 1; i <= 17; i++) begin
      d = 8'(8'h40 + i);
      exp_wr.push_back({4'((i - 1) % 16), d});
      wr_byte(d, 1'b0, 1'b1, "t6_data_ack");
    end
    i2c_stop();
    for (int a = 0; a < 16; a++)
      dbg_check(4'(a), (a == 0) ? 8'h51 : 8'(8'h41 + a), "t6_mem");

    repeat (40) @(posedge clk);
    #1;
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("byte_queue_drained", 32'(exp_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
